mul_div_arbiter: RTL
====================

Name: mul_div_arbiter

Overview:
- Shares one multiply/divide execution unit between NREQ requesters (e.g. two issue ports) over valid/ready handshakes.
- Round-robin arbitration; one operation in flight at a time.
- Latches the winner's operands, sequences the unit's in/out handshakes, and holds the result until the owning requester accepts it.
- Sits between the issue stage and the shared unit.

Parameters:
- NREQ, 2, number of requesters (2..8).
- OP_MUL, 2'd1, op code the unit executes; all other op codes are handled locally.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  reset; asynchronous, active-low (asserted when 0).
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept.
- req_src0  in  32*NREQ  operand 0, requester i at bits [32i+31:32i].
- req_src1  in  32*NREQ  operand 1, same packing.
- req_op  in  2*NREQ  op code, requester i at [2i+1:2i].
- req_sign  in  NREQ  signed-operation flag.
- resp_valid  out  NREQ  one-hot response valid to the owner.
- resp_ready  in  NREQ  per-requester response accept.
- resp_res0  out  32  result low word, shared bus.
- resp_res1  out  32  result high word, shared bus.
- unit_in_src0, unit_in_src1  out  32  operands to the unit.
- unit_in_op  out  2  op code to the unit.
- unit_in_sign  out  1  sign flag to the unit.
- unit_in_valid  out  1  request valid to the unit.
- unit_in_ready  in  1  unit accepts a request.
- unit_out_valid  in  1  unit result valid.
- unit_out_ready  out  1  arbiter accepts the result.
- unit_out_res0, unit_out_res1  in  32  unit result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, rr_ptr=0, owner=0.
  - Operand, op, sign and result registers cleared to 0.
  - Every output 0 during and after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[winner]=1 (combinational); all other req_ready=0.
  - req_ready is 0 in every non-IDLE state.
- IDLE, on a valid winner: latch src0, src1, op, sign and owner=winner.
  - op==OP_MUL: go to ISSUE.
  - Any other op: result registers <= 0, go straight to RESP; the unit is not touched.
- ISSUE:
  - unit_in_valid=1 with the latched operands.
  - Operands are held stable while unit_in_ready=0.
  - unit_in_valid & unit_in_ready: go to WAIT.
- WAIT:
  - unit_out_ready=1.
  - On unit_out_valid: capture {res1,res0} and go to RESP.
  - If unit_out_valid is already high on ISSUE exit, the capture happens on the first WAIT cycle.
  - unit_out_ready=0 outside WAIT.
- RESP:
  - resp_valid[owner]=1 with the held result; resp_res0/1 are stable until accepted.
  - On resp_ready[owner]: rr_ptr <= (owner+1) mod NREQ, go to IDLE.
  - resp_ready of non-owners is ignored.
- Latency:
  - Request accepted at edge 0; unit_in_valid high in cycle 1.
  - With a unit that completes one cycle after accept: capture at end of cycle 2, resp_valid in cycle 3.
  - Back-to-back throughput: one op per 4 cycles minimum.
- Fairness:
  - A requester holding req_valid is granted within NREQ operations.
  - A requester that drops req_valid before its grant loses nothing; there is no queueing.
- Simultaneous events:
  - Requests arriving in RESP are not granted until the following IDLE cycle.
  - The rr update and the new grant never occur in the same cycle.
- Reset mid-operation: the in-flight op is abandoned and no response is issued. The unit shares the reset domain, so it also drops its state.
- Widths: operands and results pass through unmodified. No sign extension in the arbiter; sign handling belongs to the unit.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - op code constants (OP_MUL=1, OP_NOP=0);
  - data width constant 32.
- One natural sub-module: rr_arbiter (NREQ requests + rr_ptr in, one-hot grant plus index out, purely combinational).

Test Plan:
- Single MUL, signed: req0 src0=0xFFFFFFFE, src1=3, sign=1 -> unit sees the same operands; resp_valid[0] in cycle 3; {res1,res0}=0xFFFFFFFF_FFFFFFFA.
- Fairness: req0 and req1 both valid continuously, src0=7/src1=6 and src0=5/src1=4 -> grants alternate 0,1,0,1; results 42 and 20 go to the correct port.
- Non-MUL op: req1 op=2 -> no unit_in_valid pulse; resp_valid[1] one cycle after accept with res0=res1=0.
- Backpressure: unit_in_ready held 0 for 5 cycles, then resp_ready[0] held 0 for 4 cycles -> operands and result stay stable; no new grant until the response is accepted.
- Unsigned max: src0=src1=0xFFFFFFFF, sign=0 -> {res1,res0}=0xFFFFFFFE_00000001.
- Reset mid-op: reset=0 asserted in WAIT -> all outputs 0 immediately; after release, a new req1 is granted first (rr_ptr=0, req0 idle) and completes correctly.

Source files
------------

// File: rtl/mul_div_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mul_div_arbiter_pkg : shared types and constants for the mul/div arbiter
// Rev 1.0 - initial release
// ============================================================================
package mul_div_arbiter_pkg;

   localparam int         DATA_W = 32;
   localparam logic [1:0] OP_NOP = 2'd0;
   localparam logic [1:0] OP_MUL = 2'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_div_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mul_div_arbiter_rr_arbiter : combinational round-robin pick starting at ptr
// Rev 1.0 - initial release
// ============================================================================
module mul_div_arbiter_rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   logic [NREQ-1:0] w_rot;
   logic [IDX_W:0]  w_sum;

   // Rotate so that bit 0 is the requester at ptr, then take the first set bit.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      w_sum     = '0;
      w_rot     = NREQ'({req, req} >> ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (!grant_any && w_rot[k]) begin
            grant_any = 1'b1;
            w_sum     = {1'b0, ptr} + (IDX_W+1)'(k);
         end
      end
      if (w_sum >= (IDX_W+1)'(NREQ)) begin
         w_sum = w_sum - (IDX_W+1)'(NREQ);
      end
      grant_idx = w_sum[IDX_W-1:0];
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mul_div_arbiter.sv
`default_nettype none
// ============================================================================
// mul_div_arbiter : shares one mul/div unit between NREQ requesters (round-robin)
// Rev 1.0 - initial release
// ============================================================================
module mul_div_arbiter #(
   parameter int         NREQ   = 2,
   parameter logic [1:0] OP_MUL = 2'd1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_src0,
   input  logic [32*NREQ-1:0]   req_src1,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [NREQ-1:0]      req_sign,
   output logic [NREQ-1:0]      resp_valid,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [31:0]          resp_res0,
   output logic [31:0]          resp_res1,
   output logic [31:0]          unit_in_src0,
   output logic [31:0]          unit_in_src1,
   output logic [1:0]           unit_in_op,
   output logic                 unit_in_sign,
   output logic                 unit_in_valid,
   input  logic                 unit_in_ready,
   input  logic                 unit_out_valid,
   output logic                 unit_out_ready,
   input  logic [31:0]          unit_out_res0,
   input  logic [31:0]          unit_out_res1,
   output logic                 busy
);

   import mul_div_arbiter_pkg::*;

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t              r_state;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_owner;
   logic [DATA_W-1:0]   r_src0;
   logic [DATA_W-1:0]   r_src1;
   logic [1:0]          r_op;
   logic                r_sign;
   logic [DATA_W-1:0]   r_res0;
   logic [DATA_W-1:0]   r_res1;
   logic                r_unit_in_valid;
   logic                r_unit_out_ready;
   logic [NREQ-1:0]     r_resp_valid;
   logic                r_busy;

   logic [NREQ-1:0]     w_grant;
   logic [IDX_W-1:0]    w_idx;
   logic                w_any;
   logic [IDX_W-1:0]    w_next_ptr;
   logic [DATA_W-1:0]   w_src0_arr [NREQ];
   logic [DATA_W-1:0]   w_src1_arr [NREQ];
   logic [1:0]          w_op_arr   [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_src0_arr[i] = req_src0[32*i +: 32];
      assign w_src1_arr[i] = req_src1[32*i +: 32];
      assign w_op_arr[i]   = req_op[2*i +: 2];
   end

   mul_div_arbiter_rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (r_rr_ptr),
      .grant     (w_grant),
      .grant_idx (w_idx),
      .grant_any (w_any)
   );

   assign w_next_ptr = (r_owner == IDX_W'(NREQ-1)) ? '0 : r_owner + IDX_W'(1);

   // Gated by reset so no requester sees an accept while the block is held in reset.
   assign req_ready      = (r_state == IDLE && reset) ? w_grant : '0;
   assign resp_valid     = r_resp_valid;
   assign resp_res0      = r_res0;
   assign resp_res1      = r_res1;
   assign unit_in_src0   = r_src0;
   assign unit_in_src1   = r_src1;
   assign unit_in_op     = r_op;
   assign unit_in_sign   = r_sign;
   assign unit_in_valid  = r_unit_in_valid;
   assign unit_out_ready = r_unit_out_ready;
   assign busy           = r_busy;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state          <= IDLE;
         r_rr_ptr         <= '0;
         r_owner          <= '0;
         r_src0           <= '0;
         r_src1           <= '0;
         r_op             <= '0;
         r_sign           <= 1'b0;
         r_res0           <= '0;
         r_res1           <= '0;
         r_unit_in_valid  <= 1'b0;
         r_unit_out_ready <= 1'b0;
         r_resp_valid     <= '0;
         r_busy           <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner <= w_idx;
                  r_src0  <= w_src0_arr[w_idx];
                  r_src1  <= w_src1_arr[w_idx];
                  r_op    <= w_op_arr[w_idx];
                  r_sign  <= req_sign[w_idx];
                  r_busy  <= 1'b1;
                  if (w_op_arr[w_idx] == OP_MUL) begin
                     r_unit_in_valid <= 1'b1;
                     r_state         <= ISSUE;
                  end else begin
                     // Ops the unit does not execute complete locally with a zero result.
                     r_res0       <= '0;
                     r_res1       <= '0;
                     r_resp_valid <= w_grant;
                     r_state      <= RESP;
                  end
               end
            end
            ISSUE: begin
               if (unit_in_ready) begin
                  r_unit_in_valid  <= 1'b0;
                  r_unit_out_ready <= 1'b1;
                  r_state          <= WAIT;
               end
            end
            WAIT: begin
               if (unit_out_valid) begin
                  r_res0           <= unit_out_res0;
                  r_res1           <= unit_out_res1;
                  r_unit_out_ready <= 1'b0;
                  r_resp_valid     <= NREQ'(1) << r_owner;
                  r_state          <= RESP;
               end
            end
            RESP: begin
               if (resp_ready[r_owner]) begin
                  r_rr_ptr     <= w_next_ptr;
                  r_resp_valid <= '0;
                  r_busy       <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
